// File: rtl/spi_xfer_seq_if.sv
// rtl/spi_xfer_seq_if.sv - transmit/receive byte streams and byte-engine handshake for spi_xfer_seq
interface spi_xfer_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       eng_go;
  logic [7:0] eng_datai;
  logic [7:0] eng_datao;
  logic       eng_done;
  logic       eng_busy;

  modport master (
    input  tx_data, tx_valid, rx_ready, eng_datao, eng_done, eng_busy,
    output tx_ready, rx_data, rx_valid, eng_go, eng_datai
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, eng_datao, eng_done, eng_busy,
    input  tx_ready, rx_data, rx_valid, eng_go, eng_datai
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - multi-byte SPI transaction sequencer driving an 8-bit byte engine
module spi_xfer_seq #(
  parameter int LEN_W    = 5,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             start,
  input  logic [LEN_W-1:0] nbytes,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             SSn,
  spi_xfer_seq_if.master   bus
);

  localparam int DLY_W = 8;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, RXPUSH, HOLD, FIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [DLY_W-1:0] dly;
  logic             abort_lat;
  logic             eng_go_q;
  logic [7:0]       eng_datai_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;

  assign bus.eng_go    = eng_go_q;
  assign bus.eng_datai = eng_datai_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  // A byte is only offered to the engine once it is idle and no abort is pending.
  assign bus.tx_ready  = (state == LOAD) && !bus.eng_busy && !abort;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      dly         <= '0;
      abort_lat   <= 1'b0;
      eng_go_q    <= 1'b0;
      eng_datai_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      SSn         <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      eng_go_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (nbytes != '0) begin
              cnt   <= nbytes;
              dly   <= DLY_W'(CS_SETUP);
              SSn   <= 1'b0;
              busy  <= 1'b1;
              state <= SETUP;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            abort_lat <= 1'b1;
            dly       <= DLY_W'(CS_HOLD);
            state     <= HOLD;
          end else if (dly <= DLY_W'(1)) begin
            state <= LOAD;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        LOAD: begin
          if (abort) begin
            abort_lat <= 1'b1;
            dly       <= DLY_W'(CS_HOLD);
            state     <= HOLD;
          end else if (bus.tx_valid && bus.tx_ready) begin
            eng_datai_q <= bus.tx_data;
            eng_go_q    <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          // An abort here cannot stop the engine mid-byte; remember it and drop the byte.
          if (bus.eng_done) begin
            if (abort_lat || abort) begin
              abort_lat <= 1'b1;
              dly       <= DLY_W'(CS_HOLD);
              state     <= HOLD;
            end else begin
              rx_data_q  <= bus.eng_datao;
              rx_valid_q <= 1'b1;
              state      <= RXPUSH;
            end
          end else if (abort) begin
            abort_lat <= 1'b1;
          end
        end
        RXPUSH: begin
          if (abort) begin
            rx_valid_q <= 1'b0;
            abort_lat  <= 1'b1;
            dly        <= DLY_W'(CS_HOLD);
            state      <= HOLD;
          end else if (bus.rx_ready) begin
            rx_valid_q <= 1'b0;
            cnt        <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              dly   <= DLY_W'(CS_HOLD);
              state <= HOLD;
            end else begin
              state <= LOAD;
            end
          end
        end
        HOLD: begin
          if (dly <= DLY_W'(1)) begin
            SSn     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= abort_lat;
            state   <= FIN;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        FIN: begin
          done      <= 1'b0;
          aborted   <= 1'b0;
          abort_lat <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - directed self-checking bench for spi_xfer_seq with an inverting byte-engine model
module tb_spi_xfer_seq;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] nbytes = 5'd0;
  logic       busy, done, aborted, SSn;
  logic       rx_rdy = 1'b1;

  spi_xfer_seq_if bus();

  spi_xfer_seq #(.LEN_W(5), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .nbytes(nbytes), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .SSn(SSn), .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  // transmit source: table of bytes indexed by handshakes since tx_base
  logic [7:0] tx_tab [32];
  int tx_base = 0, tx_n = 0, tx_hs = 0;
  assign bus.tx_valid = (tx_hs - tx_base) < tx_n;
  assign bus.tx_data  = tx_tab[5'(tx_hs - tx_base)];
  assign bus.rx_ready = rx_rdy;
  always @(posedge PCLK) if (bus.tx_valid && bus.tx_ready) tx_hs <= tx_hs + 1;

  // byte engine: busy 3 cycles after eng_go, then one-cycle done, returns the inverted byte
  logic [7:0] eng_sh;
  int         eng_cnt;
  logic       eng_busy_r, eng_done_r;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      eng_busy_r <= 1'b0; eng_done_r <= 1'b0; eng_cnt <= 0; eng_sh <= 8'h00;
    end else begin
      eng_done_r <= 1'b0;
      if (bus.eng_go) begin
        eng_busy_r <= 1'b1; eng_cnt <= 3; eng_sh <= bus.eng_datai;
      end else if (eng_busy_r) begin
        if (eng_cnt == 1) begin eng_busy_r <= 1'b0; eng_done_r <= 1'b1; end
        else eng_cnt <= eng_cnt - 1;
      end
    end
  end
  assign bus.eng_busy  = eng_busy_r;
  assign bus.eng_done  = eng_done_r;
  assign bus.eng_datao = ~eng_sh;

  int done_n = 0, both_n = 0, ab_n = 0, go_n = 0, ssn_lo = 0, viol_n = 0, rxv_n = 0, rx_hs = 0;
  logic [7:0] rx_log [64];
  always @(negedge PCLK) begin
    if (done) done_n++;
    if (aborted) ab_n++;
    if (done && aborted) both_n++;
    if (bus.eng_go) go_n++;
    if (!SSn) ssn_lo++;
    if (bus.eng_go && (bus.eng_busy || SSn)) viol_n++;
    if (bus.rx_valid) rxv_n++;
    if (bus.rx_valid && bus.rx_ready) begin rx_log[rx_hs & 63] = bus.rx_data; rx_hs++; end
  end

  int total = 0, bad = 0;
  int s_done, s_both, s_ab, s_go, s_ssn, s_rxv, rx_base, s_tx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_done = done_n; s_both = both_n; s_ab = ab_n; s_go = go_n;
    s_ssn = ssn_lo; s_rxv = rxv_n; rx_base = rx_hs; s_tx = tx_hs;
  endtask

  task automatic load_tx(input int n, input logic [7:0] b0, b1, b2, b3);
    tx_tab[0] = b0; tx_tab[1] = b1; tx_tab[2] = b2; tx_tab[3] = b3;
    tx_base = tx_hs; tx_n = n;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    @(posedge PCLK); #1 start = 1'b1; nbytes = n;
    @(posedge PCLK); #1 start = 1'b0;
  endtask

  // 0: done, 1: eng_go, 2: rx_valid, 3: eng_done
  task automatic wait_for(input int which, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge PCLK);
      case (which)
        0: hit = done;
        1: hit = bus.eng_go;
        2: hit = bus.rx_valid;
        default: hit = bus.eng_done;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_ssn", 32'(SSn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_go", 32'(bus.eng_go), 32'd0);
    check("rst_datai", 32'(bus.eng_datai), 32'h00);
    check("rst_txready", 32'(bus.tx_ready), 32'd0);
    check("rst_rxvalid", 32'(bus.rx_valid), 32'd0);
    check("rst_rxdata", 32'(bus.rx_data), 32'h00);
    @(posedge PCLK); #1 PRESETn = 1'b1;

    // three-byte exchange
    snap(); load_tx(3, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    pulse_start(5'd3);
    wait_for(0, "t1_done_seen");
    @(negedge PCLK);
    check("t1_rx_count", 32'(rx_hs - rx_base), 32'd3);
    check("t1_rx0", 32'(rx_log[rx_base & 63]), 32'h5A);
    check("t1_rx1", 32'(rx_log[(rx_base + 1) & 63]), 32'hC3);
    check("t1_rx2", 32'(rx_log[(rx_base + 2) & 63]), 32'h00);
    check("t1_ssn_low", 32'(ssn_lo - s_ssn), 32'd25);
    check("t1_done_n", 32'(done_n - s_done), 32'd1);
    check("t1_aborted_n", 32'(ab_n - s_ab), 32'd0);
    check("t1_go_n", 32'(go_n - s_go), 32'd3);

    // zero-length request
    snap();
    @(posedge PCLK); #1 start = 1'b1; nbytes = 5'd0;
    @(negedge PCLK); check("t2_done_pre", 32'(done), 32'd0);
    @(posedge PCLK); #1 start = 1'b0;
    @(negedge PCLK);
    check("t2_done", 32'(done), 32'd1);
    check("t2_ssn", 32'(SSn), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    @(negedge PCLK); check("t2_done_after", 32'(done), 32'd0);
    check("t2_go_n", 32'(go_n - s_go), 32'd0);
    check("t2_ssn_low", 32'(ssn_lo - s_ssn), 32'd0);

    // receive back-pressure
    snap(); load_tx(2, 8'h12, 8'h34, 8'h00, 8'h00); rx_rdy = 1'b0;
    pulse_start(5'd2);
    wait_for(2, "t3_rxv_seen");
    check("t3_rx0_data", 32'(bus.rx_data), 32'hED);
    stable = 1'b1;
    repeat (10) begin
      @(negedge PCLK);
      if (!(bus.rx_valid === 1'b1 && bus.rx_data === 8'hED)) stable = 1'b0;
    end
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_go_blocked", 32'(go_n - s_go), 32'd1);
    @(posedge PCLK); #1 rx_rdy = 1'b1;
    wait_for(0, "t3_done_seen");
    @(negedge PCLK);
    check("t3_rx_count", 32'(rx_hs - rx_base), 32'd2);
    check("t3_rx1", 32'(rx_log[(rx_base + 1) & 63]), 32'hCB);
    check("t3_go_n", 32'(go_n - s_go), 32'd2);

    // abort while the first of four bytes is shifting
    snap(); load_tx(4, 8'h01, 8'h02, 8'h03, 8'h04);
    pulse_start(5'd4);
    wait_for(1, "t4_go_seen");
    @(posedge PCLK); #1 abort = 1'b1;
    @(posedge PCLK); #1 abort = 1'b0;
    wait_for(3, "t4_engdone_seen");
    @(negedge PCLK); check("t4_hold1_ssn", 32'(SSn), 32'd0);
    @(negedge PCLK); check("t4_hold2_ssn", 32'(SSn), 32'd0);
    @(negedge PCLK);
    check("t4_fin_ssn", 32'(SSn), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_aborted", 32'(aborted), 32'd1);
    @(negedge PCLK);
    check("t4_rxv_n", 32'(rxv_n - s_rxv), 32'd0);
    check("t4_go_n", 32'(go_n - s_go), 32'd1);
    check("t4_both_n", 32'(both_n - s_both), 32'd1);

    // abort during chip-select setup
    snap(); load_tx(2, 8'h55, 8'h66, 8'h00, 8'h00);
    @(posedge PCLK); #1 start = 1'b1; nbytes = 5'd2;
    @(posedge PCLK); #1 start = 1'b0; abort = 1'b1;
    @(posedge PCLK); #1 abort = 1'b0;
    wait_for(0, "t5_done_seen");
    @(negedge PCLK);
    check("t5_go_n", 32'(go_n - s_go), 32'd0);
    check("t5_tx_n", 32'(tx_hs - s_tx), 32'd0);
    check("t5_both_n", 32'(both_n - s_both), 32'd1);

    // start while busy is ignored
    snap(); load_tx(2, 8'h81, 8'h7E, 8'h00, 8'h00);
    pulse_start(5'd2);
    repeat (3) @(posedge PCLK);
    #1 start = 1'b1; nbytes = 5'd7;
    @(posedge PCLK); #1 start = 1'b0;
    wait_for(0, "t6_done_seen");
    @(negedge PCLK);
    check("t6_rx_count", 32'(rx_hs - rx_base), 32'd2);
    check("t6_rx0", 32'(rx_log[rx_base & 63]), 32'h7E);
    check("t6_rx1", 32'(rx_log[(rx_base + 1) & 63]), 32'h81);
    check("t6_go_n", 32'(go_n - s_go), 32'd2);
    check("t6_ssn_low", 32'(ssn_lo - s_ssn), 32'd18);

    // maximum length
    snap();
    for (int i = 0; i < 32; i++) tx_tab[i] = 8'(i);
    tx_base = tx_hs; tx_n = 31;
    pulse_start(5'd31);
    wait_for(0, "t7_done_seen");
    @(negedge PCLK);
    check("t7_rx_count", 32'(rx_hs - rx_base), 32'd31);
    check("t7_rx_first", 32'(rx_log[rx_base & 63]), 32'hFF);
    check("t7_rx_last", 32'(rx_log[(rx_base + 30) & 63]), 32'hE1);
    check("t7_go_n", 32'(go_n - s_go), 32'd31);
    check("t7_ssn_low", 32'(ssn_lo - s_ssn), 32'd221);

    // reset in the middle of a byte
    snap(); load_tx(3, 8'h11, 8'h22, 8'h33, 8'h00);
    pulse_start(5'd3);
    wait_for(1, "t8_go_seen");
    @(posedge PCLK); @(posedge PCLK); #1 PRESETn = 1'b0;
    #1;
    check("t8_ssn", 32'(SSn), 32'd1);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_rxvalid", 32'(bus.rx_valid), 32'd0);
    check("t8_txready", 32'(bus.tx_ready), 32'd0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("t8_no_done", 32'(done_n - s_done), 32'd0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    snap(); load_tx(1, 8'hC3, 8'h00, 8'h00, 8'h00);
    pulse_start(5'd1);
    wait_for(0, "t8_done_seen");
    @(negedge PCLK);
    check("t8_rx_count", 32'(rx_hs - rx_base), 32'd1);
    check("t8_rx0", 32'(rx_log[rx_base & 63]), 32'h3C);
    check("t8_ssn_low", 32'(ssn_lo - s_ssn), 32'd11);
    check("t8_go_n", 32'(go_n - s_go), 32'd1);

    check("go_rule_viol", 32'(viol_n), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 5, width of the byte-count input.
REQ-002 SHALL have parameter CS_SETUP, default 2, PCLK cycles from SSn fall to the first eng_go.
REQ-003 SHALL have parameter CS_HOLD, default 2, PCLK cycles from the last byte's completion to SSn rise.
REQ-004 SHALL have port PCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port PRESETn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  request a transaction; sampled only in IDLE.
REQ-007 SHALL have port nbytes  in  LEN_W  number of bytes to exchange; latched with start.
REQ-008 SHALL have port abort  in  1  terminate the current transaction early.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port aborted  out  1  one-cycle pulse coincident with done when the end was caused by abort.
REQ-012 SHALL have ports tx_data in 8, tx_valid in 1 and tx_ready out 1: the transmit byte stream, valid/ready.
REQ-013 SHALL have ports rx_data out 8, rx_valid out 1 and rx_ready in 1: the received byte stream, valid/ready.
REQ-014 SHALL have ports eng_go out 1, eng_datai out 8, eng_datao in 8, eng_done in 1 and eng_busy in 1: the interface to the 8-bit SPI byte engine.
REQ-015 SHALL have port SSn  out  1  active-low slave select, held low for the whole transaction.

Function
REQ-016 SHALL implement the states IDLE, SETUP, LOAD, SHIFT, RXPUSH, HOLD and FIN.
REQ-017 IDLE: start=1 with nbytes!=0 SHALL latch nbytes into the remaining-byte counter, drive SSn low on the next edge, load the delay counter with CS_SETUP and enter SETUP.
REQ-018 IDLE: start=1 with nbytes=0 SHALL enter FIN directly; SSn stays high and no eng_go is issued.
REQ-019 SETUP SHALL decrement the delay counter each cycle and enter LOAD when it reaches 0; with CS_SETUP=0 it SHALL last exactly 1 cycle.
REQ-020 LOAD: tx_ready SHALL equal ~eng_busy & ~abort; a tx_valid&tx_ready handshake SHALL register tx_data into eng_datai, pulse eng_go for exactly 1 cycle on the next cycle, and enter SHIFT.
REQ-021 SHIFT SHALL wait for eng_done, then capture eng_datao into rx_data, set rx_valid and enter RXPUSH.
REQ-022 RXPUSH: rx_valid and rx_data SHALL hold stable until rx_ready=1.
REQ-023 RXPUSH: on the rx_ready handshake the block SHALL drop rx_valid and decrement the counter; if the counter becomes 0 it SHALL load CS_HOLD and enter HOLD, otherwise it SHALL enter LOAD.
REQ-024 Per byte, the minimum latency is 1 cycle tx handshake->eng_go, and 1 cycle eng_done->rx_valid.
REQ-025 HOLD SHALL count CS_HOLD cycles (minimum 1 cycle), then drive SSn high and enter FIN.
REQ-026 FIN SHALL assert done for 1 cycle and return to IDLE; busy SHALL deassert in the same cycle done is high.
REQ-027 abort in SETUP or LOAD SHALL enter HOLD on the next edge with no further eng_go.
REQ-028 abort in SHIFT SHALL be latched; the block SHALL wait for eng_done, discard the byte (no rx_valid) and enter HOLD.
REQ-029 abort in RXPUSH SHALL drop rx_valid and enter HOLD.
REQ-030 The aborted pulse SHALL be asserted in FIN whenever an abort was latched during the transaction.
REQ-031 start outside IDLE SHALL be ignored; abort in IDLE, HOLD or FIN SHALL be ignored.
REQ-032 An nbytes value of 2^LEN_W-1 SHALL be fully supported; the counter SHALL not wrap.
REQ-033 eng_go SHALL never be asserted while eng_busy=1 or while SSn=1.

Reset
REQ-034 While PRESETn=0 the block SHALL be in IDLE with SSn=1, busy=0, done=0, aborted=0, eng_go=0, eng_datai=0x00, tx_ready=0, rx_valid=0, rx_data=0x00, and all counters and the abort latch cleared.
REQ-035 Reset asserted mid-transaction SHALL force the REQ-034 values asynchronously, with no done pulse generated.

Verification
REQ-036 nbytes=3, TX bytes A5,3C,FF with the engine echoing bytes inverted -> RX 5A,C3,00; SSn low for CS_SETUP+3 bytes+CS_HOLD cycles; exactly one done pulse; aborted=0.
REQ-037 start with nbytes=0 -> done pulse 1 cycle later; SSn never low; eng_go never high.
REQ-038 nbytes=2 with rx_ready held low for 10 cycles after the first byte -> rx_data stable throughout; no second eng_go until the first RX handshake completes.
REQ-039 abort pulsed during SHIFT of byte 1 of 4 -> no rx_valid for that byte; SSn rises after CS_HOLD; done=1 and aborted=1 in the same cycle.
REQ-040 start pulsed while busy -> ignored; nbytes=2 transfer proceeds unchanged.
REQ-041 PRESETn low during SHIFT -> SSn=1 and busy=0 immediately; the next start begins cleanly.
